// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator.
// Emits runs of fixed-length packets whose data is a run-wide beat counter,
// with optional idle gaps between packets and a packet-boundary stop.
module axis_pkt_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [LEN_WIDTH-1:0]  cfg_count,
  input  logic [GAP_WIDTH-1:0]  cfg_gap,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  pkt_sent
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t                state_reg, state_next;
  logic [LEN_WIDTH-1:0]  len_reg, len_next;
  logic [LEN_WIDTH-1:0]  count_reg, count_next;
  logic [GAP_WIDTH-1:0]  gap_reg, gap_next;
  logic [GAP_WIDTH-1:0]  gap_cnt_reg, gap_cnt_next;
  logic [LEN_WIDTH-1:0]  beat_reg, beat_next;
  logic [LEN_WIDTH-1:0]  pkt_reg, pkt_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic                  stop_pend_reg, stop_pend_next;
  logic                  done_reg, done_next;

  logic                  last_beat;
  logic                  xfer;
  logic                  stop_req;
  logic                  count_hit;
  logic [LEN_WIDTH:0]    pkt_inc;

  // len_reg is always nonzero once latched, so len-1 never underflows.
  assign last_beat     = (beat_reg == (len_reg - LEN_WIDTH'(1)));
  assign m_axis_tvalid = (state_reg == SEND);
  assign m_axis_tlast  = m_axis_tvalid & last_beat;
  assign m_axis_tdata  = data_reg;
  assign xfer          = m_axis_tvalid & m_axis_tready;
  assign busy          = (state_reg != IDLE);
  assign done          = done_reg;
  assign pkt_sent      = pkt_reg;

  // A stop arriving on the same edge as the tlast transfer still counts.
  assign stop_req  = stop_pend_reg | stop;
  // One extra bit so the "last packet of the run" compare cannot wrap.
  assign pkt_inc   = {1'b0, pkt_reg} + (LEN_WIDTH + 1)'(1);
  assign count_hit = (count_reg != '0) && (pkt_inc == {1'b0, count_reg});

  // Next-state and datapath updates for the IDLE/SEND/GAP sequencer.
  always_comb begin
    state_next     = state_reg;
    len_next       = len_reg;
    count_next     = count_reg;
    gap_next       = gap_reg;
    gap_cnt_next   = gap_cnt_reg;
    beat_next      = beat_reg;
    pkt_next       = pkt_reg;
    data_next      = data_reg;
    stop_pend_next = stop_pend_reg;
    done_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          len_next       = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
          count_next     = cfg_count;
          gap_next       = cfg_gap;
          pkt_next       = '0;
          beat_next      = '0;
          data_next      = '0;
          // start together with stop yields a single-packet run.
          stop_pend_next = stop;
          state_next     = SEND;
        end
      end
      SEND: begin
        if (stop) stop_pend_next = 1'b1;
        if (xfer) begin
          data_next = data_reg + DATA_WIDTH'(1);
          if (last_beat) begin
            beat_next = '0;
            pkt_next  = (&pkt_reg) ? pkt_reg : pkt_reg + LEN_WIDTH'(1);
            if (count_hit || stop_req) begin
              state_next     = IDLE;
              stop_pend_next = 1'b0;
              done_next      = 1'b1;
            end else if (gap_reg != '0) begin
              state_next   = GAP;
              gap_cnt_next = gap_reg - GAP_WIDTH'(1);
            end
          end else begin
            beat_next = beat_reg + LEN_WIDTH'(1);
          end
        end
      end
      GAP: begin
        if (stop_req) begin
          state_next     = IDLE;
          stop_pend_next = 1'b0;
          done_next      = 1'b1;
        end else if (gap_cnt_reg == '0) begin
          state_next = SEND;
        end else begin
          gap_cnt_next = gap_cnt_reg - GAP_WIDTH'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      len_reg       <= LEN_WIDTH'(1);
      count_reg     <= '0;
      gap_reg       <= '0;
      gap_cnt_reg   <= '0;
      beat_reg      <= '0;
      pkt_reg       <= '0;
      data_reg      <= '0;
      stop_pend_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      len_reg       <= len_next;
      count_reg     <= count_next;
      gap_reg       <= gap_next;
      gap_cnt_reg   <= gap_cnt_next;
      beat_reg      <= beat_next;
      pkt_reg       <= pkt_next;
      data_reg      <= data_next;
      stop_pend_reg <= stop_pend_next;
      done_reg      <= done_next;
    end
  end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Randomized self-checking bench for axis_pkt_gen.
// Each run is predicted from the packet rules: beat n carries data n,
// tlast every efflen beats, gap idle cycles between packets, and the run
// ends after the predicted number of packets with a single done pulse.
module tb_axis_pkt_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] cfg_len = '0;
  logic [15:0] cfg_count = '0;
  logic [7:0]  cfg_gap = '0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        busy;
  logic        done;
  logic [15:0] pkt_sent;

  int checks = 0;
  int errors = 0;

  axis_pkt_gen dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_len(cfg_len), .cfg_count(cfg_count), .cfg_gap(cfg_gap),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .busy(busy), .done(done), .pkt_sent(pkt_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One run: inputs are driven and outputs sampled on the falling edge.
  task automatic run(input int len, input int cnt, input int gap, input int rdy_pct,
                     input int stop_beat, input bit ss, input bit scramble);
    int efflen, exp_pkts, n, pkts, idle;
    bit final_prev, stall_prev, fin, after_last, xfer_now, exp_last;
    logic [31:0] hold_data;
    logic        hold_last;
    efflen = (len == 0) ? 1 : len;
    if (ss) exp_pkts = 1;
    else if (stop_beat != 0) begin
      exp_pkts = (stop_beat + efflen - 1) / efflen;
      if (cnt != 0 && cnt < exp_pkts) exp_pkts = cnt;
    end else exp_pkts = cnt;
    $display("run len=%0d count=%0d gap=%0d ready=%0d%% stop_beat=%0d ss=%0d scramble=%0d -> %0d pkts",
             len, cnt, gap, rdy_pct, stop_beat, ss, scramble, exp_pkts);
    @(negedge clk);
    cfg_len = 16'(len); cfg_count = 16'(cnt); cfg_gap = 8'(gap);
    start = 1'b1; stop = ss; m_axis_tready = 1'b0;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("first_valid", 64'(m_axis_tvalid), 64'(1));
    check("busy_on", 64'(busy), 64'(1));
    n = 0; pkts = 0; idle = 0;
    final_prev = 0; stall_prev = 0; fin = 0; after_last = 0;
    hold_data = '0; hold_last = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("done", 64'(done), 64'(final_prev));
      if (final_prev) begin
        check("busy_off", 64'(busy), 64'(0));
        check("valid_off", 64'(m_axis_tvalid), 64'(0));
        check("pkt_sent_end", 64'(pkt_sent), 64'(exp_pkts));
        fin = 1;
        break;
      end
      check("busy", 64'(busy), 64'(1));
      check("pkt_sent", 64'(pkt_sent), 64'(pkts));
      if (stall_prev) begin
        check("hold_valid", 64'(m_axis_tvalid), 64'(1));
        check("hold_data", 64'(m_axis_tdata), 64'(hold_data));
        check("hold_last", 64'(m_axis_tlast), 64'(hold_last));
      end
      m_axis_tready = ($urandom_range(99) < rdy_pct);
      stop = (stop_beat != 0) && (n == stop_beat - 1) && m_axis_tvalid && m_axis_tready;
      if (scramble) begin
        cfg_len = 16'($urandom_range(1, 9));
        cfg_count = 16'($urandom_range(0, 5));
        cfg_gap = 8'($urandom_range(0, 7));
        start = ($urandom_range(3) == 0);
      end
      xfer_now = m_axis_tvalid && m_axis_tready;
      stall_prev = m_axis_tvalid && !m_axis_tready;
      hold_data = m_axis_tdata;
      hold_last = m_axis_tlast;
      final_prev = 0;
      if (m_axis_tvalid) begin
        if (after_last) begin
          check("gap_len", 64'(idle), 64'(gap));
          after_last = 0;
        end
        if (xfer_now) begin
          exp_last = ((n % efflen) == efflen - 1);
          $display("beat %0d data=%0d last=%0d", n, m_axis_tdata, m_axis_tlast);
          check("beat_data", 64'(m_axis_tdata), 64'(n));
          check("beat_last", 64'(m_axis_tlast), 64'(exp_last));
          if (exp_last) begin
            pkts++;
            if (pkts == exp_pkts) final_prev = 1;
            else begin
              after_last = 1;
              idle = 0;
            end
          end
          n++;
        end
      end else begin
        idle++;
      end
      @(negedge clk);
    end
    start = 1'b0; stop = 1'b0;
    if (!fin) check("timeout", 64'(0), 64'(1));
    @(negedge clk);
    check("done_single", 64'(done), 64'(0));
    check("idle_valid", 64'(m_axis_tvalid), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));
  endtask

  // Reset mid-packet: every output must clear without waiting for a clock.
  task automatic reset_mid_packet();
    bit seen;
    $display("run reset mid-packet len=8");
    @(negedge clk);
    cfg_len = 16'd8; cfg_count = 16'd0; cfg_gap = 8'd0;
    start = 1'b1; m_axis_tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (m_axis_tvalid && m_axis_tdata == 32'd3) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check("reach_beat3", 64'(seen), 64'(1));
    check("beat3_nolast", 64'(m_axis_tlast), 64'(0));
    rst = 1'b1;
    #1;
    check("rst_valid", 64'(m_axis_tvalid), 64'(0));
    check("rst_last", 64'(m_axis_tlast), 64'(0));
    check("rst_data", 64'(m_axis_tdata), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_pkt", 64'(pkt_sent), 64'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_valid", 64'(m_axis_tvalid), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_pkt", 64'(pkt_sent), 64'(0));
    rst = 1'b0;
    // stop while idle must not do anything
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("idle_stop_busy", 64'(busy), 64'(0));
    check("idle_stop_done", 64'(done), 64'(0));

    run(4, 2, 0, 100, 0, 0, 0);    // back-to-back packets, 8 beats
    run(3, 2, 5, 100, 0, 0, 0);    // five idle cycles between packets
    run(4, 3, 2, 50, 0, 0, 0);     // random backpressure
    run(1, 0, 0, 100, 10, 0, 0);   // continuous, stop on beat 10
    reset_mid_packet();
    run(2, 1, 0, 100, 0, 0, 0);    // first run after reset
    run(5, 3, 1, 80, 0, 0, 1);     // start/cfg churn mid-run ignored
    run(0, 3, 1, 100, 0, 0, 0);    // length 0 behaves as 1
    run(3, 0, 0, 100, 0, 1, 0);    // start+stop together: one packet
    run(3, 0, 2, 60, 7, 0, 0);     // stop mid-packet finishes that packet
    for (int r = 0; r < 4; r++)
      run($urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(0, 4),
          $urandom_range(30, 100), 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_pkt_gen.md
AXIS_PKT_GEN -- requirements
Module: axis_pkt_gen

Interface
- REQ-001: The module SHALL have parameter DATA_WIDTH, default 32, giving the stream data width in bits.
- REQ-002: The module SHALL have parameter LEN_WIDTH, default 16, giving the width of the beat-length and packet-count fields.
- REQ-003: The module SHALL have parameter GAP_WIDTH, default 8, giving the width of the inter-packet gap field.
- REQ-004: The module SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
- REQ-005: The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
- REQ-006: The module SHALL have port start, input, 1 bit: pulse that begins a run.
- REQ-007: The module SHALL have port stop, input, 1 bit: request to end a run at a packet boundary.
- REQ-008: The module SHALL have port cfg_len, input, LEN_WIDTH bits: beats per packet; a value of 0 SHALL be treated as 1.
- REQ-009: The module SHALL have port cfg_count, input, LEN_WIDTH bits: packets per run; a value of 0 SHALL mean continuous until stop.
- REQ-010: The module SHALL have port cfg_gap, input, GAP_WIDTH bits: idle cycles inserted between packets.
- REQ-011: The module SHALL have port m_axis_tdata, output, DATA_WIDTH bits: stream data.
- REQ-012: The module SHALL have port m_axis_tvalid, output, 1 bit: stream valid.
- REQ-013: The module SHALL have port m_axis_tready, input, 1 bit: stream ready (backpressure).
- REQ-014: The module SHALL have port m_axis_tlast, output, 1 bit: marks the last beat of a packet.
- REQ-015: The module SHALL have port busy, output, 1 bit: high while a run is active.
- REQ-016: The module SHALL have port done, output, 1 bit: one-cycle pulse when a run ends.
- REQ-017: The module SHALL have port pkt_sent, output, LEN_WIDTH bits: number of packets completed in the current or last run.

Function
- REQ-018: The module SHALL implement the states IDLE, SEND and GAP.
- REQ-019: In IDLE, start SHALL latch cfg_len, cfg_count and cfg_gap, clear pkt_sent and the beat and data counters, and move to SEND on the next edge.
- REQ-020: start asserted in SEND or GAP SHALL be ignored, and cfg_* changes SHALL NOT affect a run in progress.
- REQ-021: In SEND, m_axis_tvalid SHALL be 1; in IDLE and GAP, m_axis_tvalid SHALL be 0.
- REQ-022: A beat SHALL transfer on any edge where m_axis_tvalid and m_axis_tready are both 1.
- REQ-023: Once m_axis_tvalid is asserted, m_axis_tvalid, m_axis_tdata and m_axis_tlast SHALL remain stable until the beat transfers.
- REQ-024: m_axis_tdata SHALL be a run-wide beat counter: 0 on the first beat after start, incremented by 1 per transferred beat, zero-extended or truncated to DATA_WIDTH, and wrapping modulo 2^DATA_WIDTH.
- REQ-025: m_axis_tlast SHALL be 1 exactly on beat index (latched length - 1) of each packet; a length of 1 SHALL give tlast on every beat.
- REQ-026: On the tlast transfer, pkt_sent SHALL increment in the same edge and the beat index SHALL reset to 0.
- REQ-027: After the tlast transfer, the run SHALL end if latched count is nonzero and pkt_sent+1 equals that count, or if a stop is pending.
- REQ-028: Otherwise, after the tlast transfer, the module SHALL go to GAP if latched gap is nonzero, else stay in SEND with no bubble.
- REQ-029: GAP SHALL last exactly latched-gap cycles with tvalid 0, then return to SEND.
- REQ-030: stop SHALL be captured into a sticky pending flag whenever busy; in SEND it SHALL take effect only after the current packet's tlast transfer.
- REQ-031: stop in GAP, or pending on entry to GAP, SHALL end the run on the next edge.
- REQ-032: stop in IDLE SHALL have no effect.
- REQ-033: Run end SHALL return the module to IDLE, clear the pending stop, deassert busy, and pulse done for exactly one cycle.
- REQ-034: busy SHALL be 1 from the edge after start is accepted until the edge that enters IDLE.
- REQ-035: start and stop asserted together in IDLE SHALL start a run of exactly one packet.
- REQ-036: pkt_sent SHALL saturate at all-ones in continuous mode.
- REQ-037: Latency SHALL be 1 cycle from start to the first tvalid, and 1 cycle from the final tlast transfer to done.

Reset
- REQ-038: rst asserted SHALL immediately force IDLE and set m_axis_tvalid, m_axis_tlast, busy and done to 0, m_axis_tdata and pkt_sent to 0, and clear all internal counters and the pending stop, including mid-packet.
- REQ-039: The first start after rst deasserts SHALL behave exactly as a start from IDLE.

Verification
- REQ-040: The bench SHALL apply len=4, count=2, gap=0 with tready held 1, and SHALL check 8 consecutive beats with tdata 0..7, tlast at beats 3 and 7, done one cycle after beat 7, and pkt_sent=2.
- REQ-041: The bench SHALL apply len=3, count=2, gap=5, and SHALL check exactly 5 tvalid-low cycles between the beat 2 transfer and beat 3.
- REQ-042: The bench SHALL apply len=4 with tready toggled pseudo-randomly, and SHALL check that tdata and tlast never change while tvalid is high and tready is low, and that no beats are lost or duplicated.
- REQ-043: The bench SHALL apply len=1 and count=0, raise stop on the 10th beat, and SHALL check tlast on every beat, the run ending after the 10th beat, pkt_sent=10, and a single done pulse.
- REQ-044: The bench SHALL assert rst mid-packet with len=8 at beat 3, and SHALL check all outputs 0 immediately; a following start with len=2, count=1 SHALL yield tdata 0,1 with tlast on the second beat.
- REQ-045: The bench SHALL pulse start during SEND with different cfg_* values, and SHALL check that the run continues unchanged using the originally latched values.
